// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch queue holding {pc, inst} entries, with push, pop and flush.
// The head output holds its last value while the queue is empty.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [ADDR_WIDTH-1:0] push_pc_i,
    input  logic [DATA_WIDTH-1:0] push_inst_i,
    input  logic                  pop_i,
    output logic [ADDR_WIDTH-1:0] head_pc_o,
    output logic [DATA_WIDTH-1:0] head_inst_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    last_q;
    fetch_entry_t    head_entry;
    fetch_entry_t    push_entry;
    logic [PtrW-1:0] head_q;
    logic [PtrW-1:0] tail_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;
    logic            push_en;
    logic            pop_en;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CntW'(DEPTH));
    assign push_en    = push_i && !full_o;
    assign pop_en     = pop_i && !empty_o;
    assign push_entry = '{pc: push_pc_i, inst: push_inst_i};

    // Head entry, or the last presented entry once the queue runs dry.
    always_comb begin
        head_entry = last_q;
        if (!empty_o) begin
            head_entry = mem_q[head_q];
        end
    end

    assign head_pc_o   = head_entry.pc;
    assign head_inst_o = head_entry.inst;

    // Occupancy next state: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_en && !pop_en) begin
            count_d = count_q + CntW'(1);
        end else if (pop_en && !push_en) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Pointers, count and storage; flush empties the queue without touching storage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (!empty_o) begin
                last_q <= mem_q[head_q];
            end
            if (flush_i) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push_en) begin
                    mem_q[tail_q] <= push_entry;
                    tail_q        <= tail_q + PtrW'(1);
                end
                if (pop_en) begin
                    head_q <= head_q + PtrW'(1);
                end
                count_q <= count_d;
            end
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives a combinational ROM and feeds
// decode through a small registered queue with valid/ready handshake.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned           DEPTH    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  fetch_en_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  rom_ce_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_inst_i,
    output logic                  inst_valid_o,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    input  logic                  id_ready_i
);

    localparam logic [ADDR_WIDTH-1:0] ResetPcAligned = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic                  rom_ce;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  unused_redirect_lsbs;

    // Target low bits are dropped so the PC stays word aligned.
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Next state and ROM enable; the enable only sees state and registered fullness.
    always_comb begin
        state_d = state_q;
        rom_ce  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fetch_en_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                rom_ce = !fifo_full;
                if (!fetch_en_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A redirect discards this cycle's fetched word and any offered head.
    assign push = rom_ce && !redirect_i;
    assign pop  = !fifo_empty && id_ready_i && !redirect_i;

    // PC next state: redirect wins over sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
        end else if (push) begin
            pc_d = pc_q + ADDR_WIDTH'(INST_BYTES);
        end
    end

    // State and PC registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            pc_q    <= ResetPcAligned;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (redirect_i),
        .push_i      (push),
        .push_pc_i   (pc_q),
        .push_inst_i (rom_inst_i),
        .pop_i       (pop),
        .head_pc_o   (pc_o),
        .head_inst_o (inst_o),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign rom_ce_o     = rom_ce;
    assign rom_addr_o   = pc_q;
    assign inst_valid_o = !fifo_empty;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a combinational ROM returning addr ^ 0xA5A5_0000.
module tb_if_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        id_ready;

    int errors = 0;
    int checks = 0;

    if_fetch #(
        .RESET_PC (32'h8000_0000),
        .DEPTH    (2)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .fetch_en_i    (fetch_en),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .rom_ce_o      (rom_ce),
        .rom_addr_o    (rom_addr),
        .rom_inst_i    (rom_inst),
        .inst_valid_o  (inst_valid),
        .inst_o        (inst),
        .pc_o          (pc),
        .id_ready_i    (id_ready)
    );

    assign rom_inst = rom_addr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;

        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;

        #12;
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_ce", 32'(rom_ce), 32'h0);
        check("rst_addr", rom_addr, 32'h8000_0000);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", pc, 32'h0);
        rst_n = 1'b1;

        // Streaming with decode always ready.
        tick();
        fetch_en = 1'b1;
        id_ready = 1'b1;
        tick();
        check("run_ce", 32'(rom_ce), 32'h1);
        check("run_valid0", 32'(inst_valid), 32'h0);
        check("run_addr", rom_addr, 32'h8000_0000);
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_pc = 32'h8000_0000 + 32'(4 * k);
            check("stream_valid", 32'(inst_valid), 32'h1);
            check("stream_pc", pc, exp_pc);
            check("stream_inst", inst, exp_pc ^ 32'hA5A5_0000);
        end

        // Decode stalls: queue fills, ROM disabled, PC held.
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_ce", 32'(rom_ce), 32'h0);
            check("stall_valid", 32'(inst_valid), 32'h1);
            check("stall_pc", pc, 32'h8000_000C);
            check("stall_addr", rom_addr, 32'h8000_0014);
        end
        id_ready = 1'b1;
        tick();
        check("drain_pc0", pc, 32'h8000_0010);
        check("resume_ce", 32'(rom_ce), 32'h1);
        tick();
        check("drain_pc1", pc, 32'h8000_0014);
        id_ready = 1'b0;
        tick();
        check("full_ce", 32'(rom_ce), 32'h0);
        check("full_pc", pc, 32'h8000_0014);

        // Redirect with a full queue and decode ready: head is flushed.
        redirect    = 1'b1;
        redirect_pc = 32'h8000_0103;
        id_ready    = 1'b1;
        tick();
        redirect = 1'b0;
        check("redir_valid", 32'(inst_valid), 32'h0);
        check("redir_addr", rom_addr, 32'h8000_0100);
        check("redir_ce", 32'(rom_ce), 32'h1);
        tick();
        check("redir_pc", pc, 32'h8000_0100);
        check("redir_inst", inst, 32'h25A5_0100);
        tick();
        check("redir_pc1", pc, 32'h8000_0104);

        // Redirect near the top of the address space: PC wraps to zero.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        check("wrap_valid", 32'(inst_valid), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_pc = 32'hFFFF_FFF8 + 32'(4 * k);
            check("wrap_pc", pc, exp_pc);
            check("wrap_inst", inst, exp_pc ^ 32'hA5A5_0000);
        end

        // Fetch disabled mid-stream: queued entries still drain.
        fetch_en = 1'b0;
        id_ready = 1'b0;
        tick();
        check("dis_ce", 32'(rom_ce), 32'h0);
        check("dis_pc0", pc, 32'h0000_0000);
        id_ready = 1'b1;
        tick();
        check("dis_valid1", 32'(inst_valid), 32'h1);
        check("dis_pc1", pc, 32'h0000_0004);
        check("dis_ce1", 32'(rom_ce), 32'h0);
        tick();
        check("dis_empty", 32'(inst_valid), 32'h0);
        check("hold_pc", pc, 32'h0000_0004);
        check("hold_inst", inst, 32'hA5A5_0004);
        tick();
        check("dis_idle_valid", 32'(inst_valid), 32'h0);
        check("dis_idle_addr", rom_addr, 32'h0000_0008);

        // Refill then assert reset asynchronously with a full queue.
        fetch_en = 1'b1;
        id_ready = 1'b0;
        tick();
        check("refill_ce", 32'(rom_ce), 32'h1);
        tick();
        tick();
        check("refill_full_ce", 32'(rom_ce), 32'h0);
        check("refill_valid", 32'(inst_valid), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(inst_valid), 32'h0);
        check("arst_ce", 32'(rom_ce), 32'h0);
        check("arst_addr", rom_addr, 32'h8000_0000);
        check("arst_pc", pc, 32'h0);
        #2;
        rst_n    = 1'b1;
        id_ready = 1'b1;
        tick();
        check("restart_ce", 32'(rom_ce), 32'h1);
        check("restart_valid0", 32'(inst_valid), 32'h0);
        tick();
        check("restart_valid", 32'(inst_valid), 32'h1);
        check("restart_pc", pc, 32'h8000_0000);
        check("restart_inst", inst, 32'h25A5_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage sitting directly upstream of the instruction ROM and downstream-facing to decode.
- Owns the program counter and drives the ROM's chip-enable and address.
- Captures the combinationally returned instruction word into a 2-entry fetch queue.
- Presents {pc, instruction} to decode with a valid/ready handshake.
- Handles fetch enable and branch/jump redirects, including queue flush.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; equals the ROM's memory offset.
- DEPTH, 2, fetch-queue entries (power of two, ≥2).

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_n_i  input  1  reset. Asynchronous, active-low. Assertion clears state immediately; deassertion is synchronous to clk_i.
- fetch_en_i  input  1  allow fetching.
- redirect_i  input  1  control-flow redirect, one-cycle pulse.
- redirect_pc_i  input  32  redirect target.
- rom_ce_o  output  1  ROM chip enable.
- rom_addr_o  output  32  ROM byte address (word aligned).
- rom_inst_i  input  32  ROM read data, valid in the same cycle as the address (combinational ROM).
- inst_valid_o  output  1  queue head valid.
- inst_o  output  32  queue head instruction.
- pc_o  output  32  queue head PC.
- id_ready_i  input  1  decode accepts head.

## Operation
- Reset values:
  - State IDLE; pc_q = RESET_PC; queue empty.
  - rom_ce_o = 0; rom_addr_o = RESET_PC.
  - inst_valid_o = 0; inst_o = 0; pc_o = 0.
- rom_addr_o = pc_q at all times. Bits [1:0] are always 0.
- States:
  - IDLE: rom_ce_o = 0. fetch_en_i = 1 → RUN next cycle.
  - RUN: rom_ce_o = (count < DEPTH). fetch_en_i = 0 → IDLE next cycle; queued entries remain and drain normally.
- Push: occurs when rom_ce_o = 1 and redirect_i = 0. Writes {pc_q, rom_inst_i} at the tail; pc_q ← pc_q + 4, wrapping modulo 2^32 (0xFFFF_FFFC → 0).
- Pop: occurs when inst_valid_o = 1, id_ready_i = 1 and redirect_i = 0. Advances the head.
- Push and pop in the same cycle: count unchanged.
- rom_ce_o depends only on state and the registered count, not on id_ready_i, so there is no combinational path from decode to the ROM.
- inst_valid_o = (count != 0). inst_o and pc_o come from the head entry.
- When empty: inst_o and pc_o hold their last value; decode must ignore them.
- Redirect (highest priority, any state):
  - Queue cleared (count = 0).
  - pc_q ← {redirect_pc_i[31:2], 2'b00}; low bits are silently dropped.
  - No push that cycle; the word fetched at the old pc_q is discarded.
  - A head offered that cycle counts as flushed, not accepted, even if id_ready_i = 1.
  - State is unchanged.
- fetch_en_i = 0 together with redirect_i: both apply.

## Timing
- fetch_en_i rises in cycle N → RUN in N+1 → first push at end of N+1 → inst_valid_o = 1 with pc_o = RESET_PC in N+2.
- Fetch-to-decode latency: 1 cycle (registered queue).
- Throughput with id_ready_i held high: 1 instruction/cycle; steady-state count = 1.
- Queue full (count = DEPTH): rom_ce_o = 0 that cycle and pc_q holds. Fetching resumes the cycle after a pop.
- Redirect in cycle R: inst_valid_o = 0 in R+1. The target's instruction appears in R+2 (RUN, fetch_en_i = 1).
- Reset asserted mid-operation: all outputs go to their reset values immediately; in-flight entries are lost.

## Structure
- Shared package if_pkg:
  - fetch-state enum (IDLE, RUN);
  - fetch-entry struct {pc[31:0], inst[31:0]};
  - INST_BYTES = 4.
- Address and data widths come from the existing ADDR_WIDTH / DATA_WIDTH defines.
- One sub-module, fetch_fifo:
  - synchronous DEPTH-entry circular queue with push, pop and flush;
  - head/tail pointers plus a count (or an extra pointer wrap bit), so full and empty are unambiguous;
  - async active-low reset.
- if_fetch holds the PC, the state machine and the push/pop/redirect arbitration.

## Test plan
- Reset, fetch_en_i = 1, id_ready_i = 1, ROM returns addr ^ 0xA5A5_0000 → inst_valid_o from cycle 2 after enable; pc_o = 0x8000_0000, 0x8000_0004, 0x8000_0008… with matching inst_o each cycle.
- id_ready_i = 0 for 5 cycles → exactly 2 entries queued, rom_ce_o = 0 and pc_q = 0x8000_0008 held. id_ready_i = 1 → 0x8000_0000 and 0x8000_0004 delivered in order, with no loss or duplication.
- redirect_i with redirect_pc_i = 0x8000_0103 while 2 entries are queued → next cycle inst_valid_o = 0. The cycle after, pc_o = 0x8000_0100.
- Redirect to 0xFFFF_FFF8 → pc_o sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- fetch_en_i dropped mid-stream → rom_ce_o = 0 next cycle; remaining entries still drain; no new PCs appear.
- rst_n_i asserted asynchronously mid-cycle while queue is full → inst_valid_o = 0 and rom_ce_o = 0 immediately. After release, fetch restarts at 0x8000_0000.
